bus_sram_responder: RTL

//  Bus responder (slave) for the burst bus driven by the JTAG DMA initiator.

---
 rtl/bus_sram_responder_if.sv | 41 ++++
 rtl/bus_sram_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_sram_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bus_sram_responder_if                                           |
// | Purpose  : Burst bus bundle shared by the JTAG DMA initiator (master) and  |
// |            the on-chip SRAM responder (slave).                             |
// | Signals  : address_dataIN / byte_enableIN / burst_sizeIN / read_n_writeIN  |
// |            begin_transactionIN / end_transactionIN / data_validIN / busyIN |
// |            flow initiator -> responder; address_dataOUT / data_validOUT /  |
// |            end_transactionOUT / busyOUT / bus_errorOUT flow back.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface bus_sram_responder_if;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        bus_errorOUT;

  modport master (
    output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT,
           bus_errorOUT
  );

  modport slave (
    input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT,
           bus_errorOUT
  );
endinterface
`default_nettype wire

// File: rtl/bus_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bus_sram_responder                                              |
// | Purpose  : Scratch SRAM responder on the burst bus. Decodes a base window, |
// |            serves read bursts, accepts byte-masked write bursts and       |
// |            flags bursts that run past the top of memory.                   |
// | Ports    : clock  - rising-edge system clock                               |
// |            reset  - asynchronous active-high reset                         |
// |            bus    - bus_sram_responder_if.slave burst bus bundle           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bus_sram_responder #(
  parameter logic [31:0] BASE      = 32'h5000_0000,
  parameter int          ADDR_BITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  bus_sram_responder_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int TAG_W = 30 - ADDR_BITS;
  localparam logic [TAG_W-1:0] BASE_TAG = BASE[31:ADDR_BITS+2];

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_FETCH = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_RD_END   = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_WR_ERR   = 3'd5;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  // Extra MSB is the carry that marks "index ran past the top word".
  logic [ADDR_BITS:0]   idx;
  logic [8:0]           rem;
  logic [3:0]           be;
  logic [31:0]          mem [DEPTH];

  logic [31:0]          data_out;
  logic                 valid_out;
  logic                 end_out;
  logic                 err_out;

  logic                 hit;
  logic                 words_left;
  logic                 past_top;
  logic                 valid_nxt;
  logic                 end_nxt;
  logic                 err_nxt;
  logic                 load_word;
  logic                 wr_en;
  logic                 advance;

  assign hit        = bus.begin_transactionIN &&
                      (bus.address_dataIN[31:ADDR_BITS+2] == BASE_TAG);
  assign words_left = (rem != 9'd0);
  assign past_top   = idx[ADDR_BITS];
  assign advance    = load_word | wr_en;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (hit) state_nxt = bus.read_n_writeIN ? S_RD_FETCH : S_WRITE;
      end
      S_RD_FETCH: begin
        state_nxt = bus.end_transactionIN ? S_IDLE : S_READ;
      end
      S_READ: begin
        if (bus.end_transactionIN) state_nxt = S_IDLE;
        else if (bus.busyIN)       state_nxt = S_READ;
        else if (!words_left)      state_nxt = S_RD_END;
        else if (past_top)         state_nxt = S_IDLE;
      end
      S_RD_END: begin
        state_nxt = S_IDLE;
      end
      S_WRITE: begin
        if (bus.end_transactionIN)
          state_nxt = S_IDLE;
        else if (bus.data_validIN && words_left && past_top)
          state_nxt = S_WR_ERR;
      end
      S_WR_ERR: begin
        if (bus.end_transactionIN) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath control. These are next-cycle values for the
  // registered bus outputs, plus strobes for the counters and SRAM.
  always_comb begin
    valid_nxt = 1'b0;
    end_nxt   = 1'b0;
    err_nxt   = 1'b0;
    load_word = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_RD_FETCH: begin
        if (!bus.end_transactionIN) begin
          valid_nxt = 1'b1;
          load_word = 1'b1;
        end
      end
      S_READ: begin
        // READ always has a word on the bus, so busyIN stalls it here.
        if (bus.end_transactionIN) begin
          valid_nxt = 1'b0;
        end else if (bus.busyIN) begin
          valid_nxt = 1'b1;
        end else if (!words_left) begin
          end_nxt = 1'b1;
        end else if (past_top) begin
          end_nxt = 1'b1;
          err_nxt = 1'b1;
        end else begin
          valid_nxt = 1'b1;
          load_word = 1'b1;
        end
      end
      S_WRITE: begin
        // Words after the burst count is exhausted are silently dropped.
        if (bus.data_validIN && words_left) begin
          if (past_top) err_nxt = 1'b1;
          else          wr_en   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Burst address / count / byte-enable tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
      rem <= '0;
      be  <= '0;
    end else if (state == S_IDLE && hit) begin
      idx <= {1'b0, bus.address_dataIN[ADDR_BITS+1:2]};
      rem <= {1'b0, bus.burst_sizeIN} + 9'd1;
      be  <= bus.byte_enableIN;
    end else if (advance) begin
      idx <= idx + 1'b1;
      rem <= rem - 9'd1;
    end
  end

  // Word-wide SRAM with per-byte write enables; contents not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx[ADDR_BITS-1:0]][8*b +: 8] <= bus.address_dataIN[8*b +: 8];
      end
    end
  end

  // Registered bus outputs. Data is forced to zero whenever not valid so
  // the responder can share a wired-OR return bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      end_out   <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      valid_out <= valid_nxt;
      end_out   <= end_nxt;
      err_out   <= err_nxt;
      if (load_word)       data_out <= mem[idx[ADDR_BITS-1:0]];
      else if (!valid_nxt) data_out <= '0;
    end
  end

  assign bus.address_dataOUT    = data_out;
  assign bus.data_validOUT      = valid_out;
  assign bus.end_transactionOUT = end_out;
  assign bus.bus_errorOUT       = err_out;
  assign bus.busyOUT            = 1'b0;

endmodule
`default_nettype wire
